des_round_controller: RTL and testbench

DES_ROUND_CONTROLLER -- requirements
Module: des_round_controller

---
 rtl/des_round_controller_if.sv | 34 +++
 rtl/des_round_controller.sv | 176 +++++++++++++++++
 tb/tb_des_round_controller.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/des_round_controller_if.sv
// des_round_controller_if: block handshake, result handshake and key-schedule
// link for des_round_controller. The slave modport is the controller side.
// Optional macro DES_CTRL_ABORT_EN adds the i_abort input.
interface des_round_controller_if;
  logic        i_valid;
  logic        o_ready;
  logic [63:0] i_data;
  logic        i_decrypt;
  logic [3:0]  o_round_sel;
  logic [47:0] i_round_key;
  logic        o_valid;
  logic        i_ready;
  logic [63:0] o_data;
  logic        o_busy;
`ifdef DES_CTRL_ABORT_EN
  logic        i_abort;
`endif

  modport slave (
    input  i_valid, i_data, i_decrypt, i_round_key, i_ready,
`ifdef DES_CTRL_ABORT_EN
    input  i_abort,
`endif
    output o_ready, o_round_sel, o_valid, o_data, o_busy
  );

  modport master (
    output i_valid, i_data, i_decrypt, i_round_key, i_ready,
`ifdef DES_CTRL_ABORT_EN
    output i_abort,
`endif
    input  o_ready, o_round_sel, o_valid, o_data, o_busy
  );
endinterface

// File: rtl/des_round_controller.sv
// des_round_controller: iterative 16-round DES engine, one Feistel round per
// cycle. Round keys come from an external key schedule addressed by
// o_round_sel. Optional macro DES_CTRL_ABORT_EN enables i_abort.

// DES_Function: round function f(R, K) = P(S(E(R) xor K)).
module DES_Function (
  input  logic [31:0] i_r,
  input  logic [47:0] i_key,
  output logic [31:0] o_f
);
  localparam int unsigned E_T [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

  localparam int unsigned P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

  // Each S-box row-major (row = outer bits, col = inner four), entry 0 at MSB.
  localparam logic [255:0] S_T [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  function automatic logic [3:0] sbox(input logic [2:0] n, input logic [5:0] b);
    logic [5:0] idx;
    idx = {b[5], b[0], b[4:1]};
    return S_T[n][{~idx, 2'b00} +: 4];
  endfunction

  logic [47:0] w_e;
  logic [47:0] w_x;
  logic [31:0] w_s;

  // Expansion, key mix, substitution and permutation.
  always_comb begin
    w_e = '0;
    w_s = '0;
    o_f = '0;
    for (int unsigned i = 0; i < 48; i++)
      w_e[6'(47 - i)] = i_r[5'(32 - E_T[i])];
    w_x = w_e ^ i_key;
    for (int unsigned j = 0; j < 8; j++)
      w_s[5'(31 - 4 * j) -: 4] = sbox(3'(j), w_x[6'(47 - 6 * j) -: 6]);
    for (int unsigned i = 0; i < 32; i++)
      o_f[5'(31 - i)] = w_s[5'(32 - P_T[i])];
  end
endmodule

module des_round_controller (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  des_round_controller_if.slave bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ROUND = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam int unsigned IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10,  2, 60, 52, 44, 36, 28, 20, 12,  4,
    62, 54, 46, 38, 30, 22, 14,  6, 64, 56, 48, 40, 32, 24, 16,  8,
    57, 49, 41, 33, 25, 17,  9,  1, 59, 51, 43, 35, 27, 19, 11,  3,
    61, 53, 45, 37, 29, 21, 13,  5, 63, 55, 47, 39, 31, 23, 15,  7};

  localparam int unsigned FP_T [64] = '{
    40,  8, 48, 16, 56, 24, 64, 32, 39,  7, 47, 15, 55, 23, 63, 31,
    38,  6, 46, 14, 54, 22, 62, 30, 37,  5, 45, 13, 53, 21, 61, 29,
    36,  4, 44, 12, 52, 20, 60, 28, 35,  3, 43, 11, 51, 19, 59, 27,
    34,  2, 42, 10, 50, 18, 58, 26, 33,  1, 41,  9, 49, 17, 57, 25};

  function automatic logic [63:0] perm64(input logic [63:0] d, input logic fin);
    logic [63:0] o;
    o = '0;
    for (int unsigned i = 0; i < 64; i++)
      o[6'(63 - i)] = d[6'(64 - (fin ? FP_T[i] : IP_T[i]))];
    return o;
  endfunction

  logic [1:0]  r_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_l;
  logic [31:0] r_r;
  logic        r_dec;
  logic [63:0] r_odata;
  logic        r_ovalid;

  logic [31:0] w_f;
  logic [31:0] w_r_next;
  logic [63:0] w_ip;
  logic [63:0] w_fp;
  logic [3:0]  w_round_sel;
  logic        w_abort;

`ifdef DES_CTRL_ABORT_EN
  assign w_abort = bus.i_abort;
`else
  assign w_abort = 1'b0;
`endif

  DES_Function u_f (
    .i_r   (r_r),
    .i_key (bus.i_round_key),
    .o_f   (w_f)
  );

  // Round datapath, permutations and key-index selection (15-r is ~r).
  always_comb begin
    w_r_next    = r_l ^ w_f;
    w_ip        = perm64(bus.i_data, 1'b0);
    w_fp        = perm64({w_r_next, r_r}, 1'b1);
    w_round_sel = '0;
    if (r_state == ROUND)
      w_round_sel = r_dec ? ~r_cnt : r_cnt;
  end

  assign bus.o_ready     = (r_state == IDLE);
  assign bus.o_busy      = (r_state != IDLE);
  assign bus.o_valid     = r_ovalid;
  assign bus.o_data      = r_odata;
  assign bus.o_round_sel = w_round_sel;

  // Control FSM: accept, 16 rounds, hold result until consumed.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_l      <= '0;
      r_r      <= '0;
      r_dec    <= 1'b0;
      r_odata  <= '0;
      r_ovalid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.i_valid) begin
            {r_l, r_r} <= w_ip;
            r_dec      <= bus.i_decrypt;
            r_cnt      <= '0;
            r_state    <= ROUND;
          end
        end
        ROUND: begin
          if (w_abort) begin
            r_state  <= IDLE;
            r_ovalid <= 1'b0;
          end else begin
            r_l <= r_r;
            r_r <= w_r_next;
            // Last round: result is captured from the unswapped next-state values.
            if (r_cnt == 4'd15) begin
              r_odata  <= w_fp;
              r_ovalid <= 1'b1;
              r_state  <= DONE;
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end
        end
        DONE: begin
          if (w_abort || bus.i_ready) begin
            r_state  <= IDLE;
            r_ovalid <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_des_round_controller.sv
// Self-checking bench for des_round_controller with a key-schedule model.
module tb_des_round_controller;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  des_round_controller_if bus();

  des_round_controller dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  localparam logic [63:0] KEY = 64'h133457799BBCDFF1;
  localparam logic [63:0] PT  = 64'h0123456789ABCDEF;
  localparam logic [63:0] CT  = 64'h85E813540F0AB405;

  localparam int unsigned PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int unsigned PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int unsigned SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  function automatic logic [47:0] subkey(input logic [3:0] n);
    logic [55:0] k56;
    logic [55:0] cd;
    logic [27:0] c;
    logic [27:0] d;
    logic [47:0] k;
    for (int i = 0; i < 56; i++) k56[6'(55 - i)] = KEY[6'(64 - PC1_T[i])];
    c = k56[55:28];
    d = k56[27:0];
    for (int i = 0; i <= int'(n); i++) begin
      if (SHIFTS[i] == 1) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end else begin
        c = {c[25:0], c[27:26]};
        d = {d[25:0], d[27:26]};
      end
    end
    cd = {c, d};
    for (int i = 0; i < 48; i++) k[6'(47 - i)] = cd[6'(56 - PC2_T[i])];
    return k;
  endfunction

  assign bus.i_round_key = subkey(bus.o_round_sel);

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [63:0] d, input logic dec, input logic [63:0] exp);
    @(negedge clk);
    check("accept_ready", 64'(bus.o_ready), 64'd1);
    bus.i_valid   = 1'b1;
    bus.i_data    = d;
    bus.i_decrypt = dec;
    @(posedge clk);
    exp_q.push_back(exp);
    #1 bus.i_valid = 1'b0;
  endtask

  // Called just after the accept edge; ends on the negedge where the result is visible.
  task automatic run_rounds(input logic dec);
    logic [3:0] e;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      e = dec ? 4'(15 - k) : 4'(k);
      check("round_sel", 64'(bus.o_round_sel), 64'(e));
      check("round_flags", 64'({bus.o_busy, bus.o_valid, bus.o_ready}), 64'(3'b100));
    end
    @(negedge clk);
    check("valid_latency", 64'(bus.o_valid), 64'd1);
    check("done_flags", 64'({bus.o_busy, bus.o_ready, bus.o_round_sel}), 64'(6'b100000));
    check("scoreboard_size", 64'(exp_q.size()), 64'd1);
    if (exp_q.size() > 0) check("result", bus.o_data, exp_q.pop_front());
  endtask

  task automatic handshake();
    bus.i_ready = 1'b1;
    @(negedge clk);
    check("post_handshake", 64'({bus.o_valid, bus.o_ready, bus.o_busy}), 64'(3'b010));
    bus.i_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_valid   = 1'b0;
    bus.i_data    = '0;
    bus.i_decrypt = 1'b0;
    bus.i_ready   = 1'b0;
`ifdef DES_CTRL_ABORT_EN
    bus.i_abort   = 1'b0;
`endif
    #12;
    check("reset_flags", 64'({bus.o_ready, bus.o_valid, bus.o_busy}), 64'(3'b100));
    check("reset_round_sel", 64'(bus.o_round_sel), 64'd0);
    check("reset_data", bus.o_data, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Encrypt then decrypt the reference vector.
    send(PT, 1'b0, CT);
    run_rounds(1'b0);
    handshake();
    send(CT, 1'b1, PT);
    run_rounds(1'b1);
    handshake();

    // Backpressure: result holds, new offers ignored.
    send(PT, 1'b0, CT);
    run_rounds(1'b0);
    for (int k = 0; k < 10; k++) begin
      bus.i_valid = 1'b1;
      bus.i_data  = {$urandom, $urandom};
      @(negedge clk);
      check("bp_data", bus.o_data, CT);
      check("bp_flags", 64'({bus.o_valid, bus.o_ready, bus.o_busy}), 64'(3'b101));
    end
    bus.i_valid = 1'b0;
    handshake();

    // Back-to-back with i_valid and i_ready held high.
    @(negedge clk);
    bus.i_valid   = 1'b1;
    bus.i_data    = PT;
    bus.i_decrypt = 1'b0;
    bus.i_ready   = 1'b1;
    @(posedge clk);
    exp_q.push_back(CT);
    #1;
    bus.i_data    = CT;
    bus.i_decrypt = 1'b1;
    run_rounds(1'b0);
    @(negedge clk);
    check("b2b_idle", 64'({bus.o_valid, bus.o_ready, bus.o_busy}), 64'(3'b010));
    @(posedge clk);
    exp_q.push_back(PT);
    #1 bus.i_valid = 1'b0;
    run_rounds(1'b1);
    handshake();

    // Asynchronous reset at r=7 discards the block.
    send(PT, 1'b0, CT);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("pre_reset_sel", 64'(bus.o_round_sel), 64'(k));
    end
    rst_n = 1'b0;
    #1;
    check("mid_reset_flags", 64'({bus.o_ready, bus.o_valid, bus.o_busy}), 64'(3'b100));
    check("mid_reset_sel", 64'(bus.o_round_sel), 64'd0);
    check("mid_reset_data", bus.o_data, 64'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("post_reset_quiet", 64'({bus.o_valid, bus.o_busy}), 64'd0);
    end
    send(CT, 1'b1, PT);
    run_rounds(1'b1);
    handshake();

`ifdef DES_CTRL_ABORT_EN
    // Abort at r=3, then a clean block.
    send(PT, 1'b0, CT);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("pre_abort_sel", 64'(bus.o_round_sel), 64'(k));
    end
    bus.i_abort = 1'b1;
    @(negedge clk);
    bus.i_abort = 1'b0;
    check("abort_flags", 64'({bus.o_valid, bus.o_ready, bus.o_busy}), 64'(3'b010));
    exp_q.delete();
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      check("abort_no_valid", 64'(bus.o_valid), 64'd0);
    end
    send(PT, 1'b0, CT);
    run_rounds(1'b0);
    handshake();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
